// File: rtl/fetch_decode_stage.sv
// Fetch stage with a 2-entry skid queue and the fetch-to-decode register.
// Optional perf counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_decode_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallD_i,
    input  logic                  FlushD_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    output logic                  ImemReqF_o,
    output logic [DATA_WIDTH-1:0] PCF_o,
    input  logic [DATA_WIDTH-1:0] InstrF_i,
    output logic [DATA_WIDTH-1:0] InstrD_o,
    output logic [DATA_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] PCPlus4D_o,
    output logic                  ValidD_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           StallCntD_o,
    output logic [31:0]           FlushCntF_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] r_pcf;
    logic                  r_inf_v;
    logic [DATA_WIDTH-1:0] r_inf_pc;

    logic [DATA_WIDTH-1:0] r_q_instr [2];
    logic [DATA_WIDTH-1:0] r_q_pc    [2];
    logic [1:0]            r_cnt;
    logic                  r_rp;
    logic                  r_wp;

    logic [DATA_WIDTH-1:0] r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_pcp4_d;
    logic                  r_valid_d;

    logic                  w_dload;
    logic                  w_qpop;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_src_instr;
    logic [DATA_WIDTH-1:0] w_src_pc;

    // Queue/bypass steering and the issue rule that keeps a slot free for every response
    always_comb begin
        w_dload     = !StallD_i || !r_valid_d;
        w_qpop      = w_dload && (r_cnt != 2'd0);
        w_bypass    = w_dload && (r_cnt == 2'd0) && r_inf_v;
        w_push      = r_inf_v && !w_bypass;
        w_pop       = w_qpop || w_bypass;
        w_occ       = {1'b0, r_cnt} + {2'b00, r_inf_v} - {2'b00, w_pop};
        w_issue     = !rst && !FlushD_i && (w_occ < 3'd2);
        w_src_instr = r_qpop_sel_instr();
        w_src_pc    = r_qpop_sel_pc();
    end

    function automatic logic [DATA_WIDTH-1:0] r_qpop_sel_instr();
        return (r_cnt != 2'd0) ? r_q_instr[r_rp] : InstrF_i;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] r_qpop_sel_pc();
        return (r_cnt != 2'd0) ? r_q_pc[r_rp] : r_inf_pc;
    endfunction

    // PC and in-flight request tracking; a flush redirects with bit 0 cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcf    <= RESET_PC;
            r_inf_v  <= 1'b0;
            r_inf_pc <= '0;
        end else if (FlushD_i) begin
            r_pcf   <= {PCTargetE_i[DATA_WIDTH-1:1], 1'b0};
            r_inf_v <= 1'b0;
        end else if (w_issue) begin
            r_inf_v  <= 1'b1;
            r_inf_pc <= r_pcf;
            r_pcf    <= r_pcf + PC_STEP;
        end else begin
            r_inf_v <= 1'b0;
        end
    end

    // Skid queue: responses not taken by the bypass are parked here in order
    always_ff @(posedge clk) begin
        if (rst || FlushD_i) begin
            r_cnt <= 2'd0;
            r_rp  <= 1'b0;
            r_wp  <= 1'b0;
        end else begin
            if (w_push) begin
                r_q_instr[r_wp] <= InstrF_i;
                r_q_pc[r_wp]    <= r_inf_pc;
                r_wp            <= ~r_wp;
            end
            if (w_qpop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_qpop};
        end
    end

    // Decode register: load queue head, bypassed response, or a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= '0;
            r_pcp4_d  <= '0;
            r_valid_d <= 1'b0;
        end else if (FlushD_i) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (w_dload) begin
            if (w_pop) begin
                r_instr_d <= w_src_instr;
                r_pc_d    <= w_src_pc;
                r_pcp4_d  <= w_src_pc + PC_STEP;
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Cycles a real instruction sits stalled, and redirect count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallD_i && r_valid_d) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (FlushD_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign StallCntD_o = r_stall_cnt;
    assign FlushCntF_o = r_flush_cnt;
`endif

    assign ImemReqF_o = w_issue;
    assign PCF_o      = r_pcf;
    assign InstrD_o   = r_instr_d;
    assign PCD_o      = r_pc_d;
    assign PCPlus4D_o = r_pcp4_d;
    assign ValidD_o   = r_valid_d;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage; memory returns the address as data.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallD_i = 1'b0;
    logic        FlushD_i = 1'b0;
    logic [31:0] PCTargetE_i = '0;
    logic [31:0] InstrF_i = '0;
    logic        ImemReqF_o;
    logic [31:0] PCF_o;
    logic [31:0] InstrD_o;
    logic [31:0] PCD_o;
    logic [31:0] PCPlus4D_o;
    logic        ValidD_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCntD_o;
    logic [31:0] FlushCntF_o;
`endif

    int n_tot = 0;
    int n_bad = 0;

    fetch_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallD_i    (StallD_i),
        .FlushD_i    (FlushD_i),
        .PCTargetE_i (PCTargetE_i),
        .ImemReqF_o  (ImemReqF_o),
        .PCF_o       (PCF_o),
        .InstrF_i    (InstrF_i),
        .InstrD_o    (InstrD_o),
        .PCD_o       (PCD_o),
        .PCPlus4D_o  (PCPlus4D_o),
        .ValidD_o    (ValidD_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .StallCntD_o (StallCntD_o),
        .FlushCntF_o (FlushCntF_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ImemReqF_o) InstrF_i <= PCF_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_tot++;
        if (ValidD_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid got %b want 0", ValidD_o);
        end
        n_tot++;
        if (InstrD_o !== 32'h00000013) begin
            n_bad++; $display("FAIL rst_instr got %h want 00000013", InstrD_o);
        end
        n_tot++;
        if (PCD_o !== 32'h0 || PCPlus4D_o !== 32'h0) begin
            n_bad++; $display("FAIL rst_pcd got %h/%h want 0/0", PCD_o, PCPlus4D_o);
        end
        n_tot++;
        if (PCF_o !== 32'hBFC00000) begin
            n_bad++; $display("FAIL rst_pcf got %h want bfc00000", PCF_o);
        end
        n_tot++;
        if (ImemReqF_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_req got %b want 0", ImemReqF_o);
        end
        rst = 1'b0;
        #1;
        n_tot++;
        if (ImemReqF_o !== 1'b1) begin
            n_bad++; $display("FAIL first_req got %b want 1", ImemReqF_o);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        step();
        n_tot++;
        if (ValidD_o !== 1'b0) begin
            n_bad++; $display("FAIL lat_bubble got %b want 0", ValidD_o);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            e = 32'hBFC00000 + 32'(4 * i);
            n_tot++;
            if (ValidD_o !== 1'b1 || PCD_o !== e || InstrD_o !== e
                || PCPlus4D_o !== e + 32'd4) begin
                n_bad++;
                $display("FAIL stream%0d got v=%b pc=%h in=%h p4=%h want pc=%h",
                         i, ValidD_o, PCD_o, InstrD_o, PCPlus4D_o, e);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        step();
        n_tot++;
        if (PCD_o !== 32'hBFC00008) begin
            n_bad++; $display("FAIL pre_stall got %h want bfc00008", PCD_o);
        end
        StallD_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tot++;
            if (PCD_o !== 32'hBFC00008 || ValidD_o !== 1'b1
                || ImemReqF_o !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold%0d got pc=%h v=%b req=%b want bfc00008/1/0",
                         i, PCD_o, ValidD_o, ImemReqF_o);
            end
        end
        StallD_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            e = 32'hBFC0000C + 32'(4 * i);
            n_tot++;
            if (PCD_o !== e || ValidD_o !== 1'b1 || InstrD_o !== e) begin
                n_bad++;
                $display("FAIL drain%0d got pc=%h v=%b in=%h want %h",
                         i, PCD_o, ValidD_o, InstrD_o, e);
            end
        end
    endtask

    task automatic test_flush();
        StallD_i = 1'b1;
        repeat (3) step();
        StallD_i = 1'b0;
        FlushD_i = 1'b1;
        PCTargetE_i = 32'h00000101;
        #1;
        n_tot++;
        if (ImemReqF_o !== 1'b0) begin
            n_bad++; $display("FAIL flush_req got %b want 0", ImemReqF_o);
        end
        step();
        FlushD_i = 1'b0;
        n_tot++;
        if (ValidD_o !== 1'b0 || InstrD_o !== 32'h00000013
            || PCF_o !== 32'h00000100) begin
            n_bad++;
            $display("FAIL flush_out got v=%b in=%h pcf=%h want 0/00000013/00000100",
                     ValidD_o, InstrD_o, PCF_o);
        end
        #1;
        n_tot++;
        if (ImemReqF_o !== 1'b1) begin
            n_bad++; $display("FAIL target_req got %b want 1", ImemReqF_o);
        end
        step();
        n_tot++;
        if (ValidD_o !== 1'b0) begin
            n_bad++; $display("FAIL flush_gap got %b want 0", ValidD_o);
        end
        step();
        n_tot++;
        if (ValidD_o !== 1'b1 || PCD_o !== 32'h100 || PCPlus4D_o !== 32'h104
            || InstrD_o !== 32'h100) begin
            n_bad++;
            $display("FAIL target got v=%b pc=%h p4=%h in=%h want 1/100/104/100",
                     ValidD_o, PCD_o, PCPlus4D_o, InstrD_o);
        end
        step();
        n_tot++;
        if (PCD_o !== 32'h104 || ValidD_o !== 1'b1) begin
            n_bad++; $display("FAIL target_next got %h/%b want 104/1", PCD_o, ValidD_o);
        end
    endtask

    task automatic test_flush_stall_wrap();
        StallD_i = 1'b1;
        FlushD_i = 1'b1;
        PCTargetE_i = 32'hFFFFFFFC;
        step();
        StallD_i = 1'b0;
        FlushD_i = 1'b0;
        n_tot++;
        if (ValidD_o !== 1'b0 || PCF_o !== 32'hFFFFFFFC) begin
            n_bad++;
            $display("FAIL flush_wins got v=%b pcf=%h want 0/fffffffc", ValidD_o, PCF_o);
        end
        step();
        step();
        n_tot++;
        if (PCD_o !== 32'hFFFFFFFC || PCPlus4D_o !== 32'h0 || ValidD_o !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap0 got pc=%h p4=%h v=%b want fffffffc/0/1",
                     PCD_o, PCPlus4D_o, ValidD_o);
        end
        step();
        n_tot++;
        if (PCD_o !== 32'h0 || PCPlus4D_o !== 32'h4 || InstrD_o !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap1 got pc=%h p4=%h in=%h want 0/4/0",
                     PCD_o, PCPlus4D_o, InstrD_o);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        StallD_i = 1'b1;
        repeat (3) step();
        StallD_i = 1'b0;
        FlushD_i = 1'b1;
        step();
        FlushD_i = 1'b0;
        step();
        FlushD_i = 1'b1;
        step();
        FlushD_i = 1'b0;
        n_tot++;
        if (StallCntD_o !== 32'd3 || FlushCntF_o !== 32'd2) begin
            n_bad++;
            $display("FAIL perf got s=%0d f=%0d want 3/2", StallCntD_o, FlushCntF_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tot++;
        if (StallCntD_o !== 32'd0 || FlushCntF_o !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_rst got s=%0d f=%0d want 0/0", StallCntD_o, FlushCntF_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_stall_wrap();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
